// File: rtl/pl_alu_rns_mc_if.sv
// pl_alu_rns_mc_if
// Handshake and data bundle for the RNS ALU.
//   master : operand producer / result consumer (drives in_valid, op, acc_clr,
//            a, b, out_ready, err_clr)
//   slave  : the ALU (drives in_ready, out_valid, result, range_err)
// a, b and result carry CH residues of W bits each, channel 0 in the LSBs.
interface pl_alu_rns_mc_if #(
  parameter int CH = 3,
  parameter int W  = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            acc_clr;
  logic [CH*W-1:0] a;
  logic [CH*W-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [CH*W-1:0] result;
  logic            range_err;
  logic            err_clr;

  modport master (
    output in_valid, op, acc_clr, a, b, out_ready, err_clr,
    input  in_ready, out_valid, result, range_err
  );

  modport slave (
    input  in_valid, op, acc_clr, a, b, out_ready, err_clr,
    output in_ready, out_valid, result, range_err
  );
endinterface

// File: rtl/pl_alu_rns_mc.sv
// pl_alu_rns_mc
// Two-stage residue-number-system ALU: add, sub, mul and multiply-accumulate,
// run in lockstep on CH channels, each with its own modulus from MODS.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pl_alu_rns_mc_if slave port (valid/ready in, valid/ready out,
//           sticky range_err with err_clr)
// Stage 1 holds the raw (unreduced) op result for each channel. Stage 2 holds
// the reduced result and the accumulator. Both stages advance on one enable,
// so a stall freezes the whole pipe.
module pl_alu_rns_mc #(
  parameter int                  CH   = 3,
  parameter int                  W    = 8,
  parameter logic [CH*(W+1)-1:0] MODS = {9'd129, 9'd128, 9'd127}
) (
  input logic            clk,
  input logic            rst_n,
  pl_alu_rns_mc_if.slave bus
);
  // Wide enough for a full W x W product and for a'+m-b'.
  localparam int RW = (2 * W > W + 2) ? 2 * W : W + 2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MAC = 2'd3;

  logic          w_en;
  logic          w_accept;
  logic [CH-1:0] w_rng_ch;
  logic [CH*W-1:0] w_result;

  logic       r_s1_vld;
  logic [1:0] r_s1_op;
  logic       r_s1_clr;
  logic       r_out_vld;
  logic       r_range_err;

  assign w_en     = !r_out_vld || bus.out_ready;
  assign w_accept = bus.in_valid && w_en;

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_vld;
  assign bus.result    = w_result;
  assign bus.range_err = r_range_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_op   <= OP_ADD;
      r_s1_clr  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_en) begin
      r_s1_vld  <= bus.in_valid;
      r_s1_op   <= bus.op;
      r_s1_clr  <= bus.acc_clr;
      r_out_vld <= r_s1_vld;
    end
  end

  // Set has priority over clear so a new error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_range_err <= 1'b0;
    else if (w_accept && (|w_rng_ch))
      r_range_err <= 1'b1;
    else if (bus.err_clr)
      r_range_err <= 1'b0;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    localparam logic [RW-1:0] M = RW'(MODS[g*(W+1) +: W+1]);

    logic [RW-1:0] w_a;
    logic [RW-1:0] w_b;
    logic [RW-1:0] w_ar;
    logic [RW-1:0] w_br;
    logic [RW-1:0] w_raw;
    logic [RW-1:0] w_red;
    logic [RW-1:0] w_acc_base;
    logic [W-1:0]  w_mac;
    logic [W-1:0]  w_res;

    logic [RW-1:0] r_s1_raw;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_res;

    assign w_a  = RW'(bus.a[g*W +: W]);
    assign w_b  = RW'(bus.b[g*W +: W]);
    // For M = 2^W the remainder is the identity, i.e. plain truncation.
    assign w_ar = w_a % M;
    assign w_br = w_b % M;
    assign w_rng_ch[g] = (w_a >= M) || (w_b >= M);

    // Sub adds M first so the raw value is never negative.
    always_comb begin
      case (bus.op)
        OP_ADD:  w_raw = w_ar + w_br;
        OP_SUB:  w_raw = w_ar + M - w_br;
        default: w_raw = w_ar * w_br;
      endcase
    end

    // Stage 2: reduce, then fold into the accumulator for mac.
    // acc_clr on a mac makes the old accumulator read as zero.
    assign w_red      = r_s1_raw % M;
    assign w_acc_base = (r_s1_op == OP_MAC && !r_s1_clr) ? RW'(r_acc) : '0;
    assign w_mac      = W'((w_acc_base + w_red) % M);
    assign w_res      = (r_s1_op == OP_MAC) ? w_mac : W'(w_red);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_raw <= '0;
        r_acc    <= '0;
        r_res    <= '0;
      end else if (w_en) begin
        r_s1_raw <= w_raw;
        // Bubbles leave both result and accumulator untouched.
        if (r_s1_vld) begin
          r_res <= w_res;
          if (r_s1_op == OP_MAC)
            r_acc <= w_mac;
          else if (r_s1_clr)
            r_acc <= '0;
        end
      end
    end

    assign w_result[g*W +: W] = r_res;
  end
endmodule

// File: tb/tb_pl_alu_rns_mc.sv
module tb_pl_alu_rns_mc;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int M [CH] = '{127, 128, 129};

  typedef logic [CH*W-1:0] vec_t;

  typedef struct {
    logic [1:0] op;
    logic       clr;
    vec_t       a;
    vec_t       b;
    vec_t       exp;
  } vector_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pl_alu_rns_mc_if #(.CH(CH), .W(W)) bus ();

  pl_alu_rns_mc #(.CH(CH), .W(W), .MODS({9'd129, 9'd128, 9'd127})) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   macc [CH];
  logic m_err;
  vec_t exp_q [$];
  logic last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2);
    vec_t v;
    v[0*W +: W] = W'(c0);
    v[1*W +: W] = W'(c1);
    v[2*W +: W] = W'(c2);
    return v;
  endfunction

  // Reference: residue arithmetic straight from the operation definitions.
  function automatic vec_t model(input logic [1:0] op, input logic clr, input vec_t a, input vec_t b);
    vec_t r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      int ai, bi, v;
      ai = int'(a[i*W +: W]) % M[i];
      bi = int'(b[i*W +: W]) % M[i];
      case (op)
        2'd0: v = (ai + bi) % M[i];
        2'd1: v = (ai - bi + M[i]) % M[i];
        2'd2: v = (ai * bi) % M[i];
        default: begin
          v = ((clr ? 0 : macc[i]) + ai * bi) % M[i];
          macc[i] = v;
        end
      endcase
      if (op != 2'd3 && clr) macc[i] = 0;
      r[i*W +: W] = W'(v);
    end
    return r;
  endfunction

  function automatic logic oor(input vec_t a, input vec_t b);
    logic e;
    e = 1'b0;
    for (int i = 0; i < CH; i++)
      if (int'(a[i*W +: W]) >= M[i] || int'(b[i*W +: W]) >= M[i]) e = 1'b1;
    return e;
  endfunction

  // One clock: inputs already driven at the falling edge; observe the
  // handshakes just before the rising edge, then check range_err after it.
  task automatic step(input bit have_exp, input vec_t exp_v);
    logic fin, fout, e;
    vec_t mv;
    #1;
    fin  = bus.in_valid && bus.in_ready;
    fout = bus.out_valid && bus.out_ready;
    if (fout) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got result %0h with no transaction pending", bus.result);
      end else begin
        chk("result", bus.result, exp_q.pop_front());
      end
    end
    last_acc = fin;
    if (fin) begin
      e  = oor(bus.a, bus.b);
      mv = model(bus.op, bus.acc_clr, bus.a, bus.b);
      exp_q.push_back(have_exp ? exp_v : mv);
      if (e) m_err = 1'b1;
      else if (bus.err_clr) m_err = 1'b0;
    end else if (bus.err_clr) begin
      m_err = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("range_err", bus.range_err, m_err);
  endtask

  task automatic drive(input logic [1:0] op, input logic clr, input vec_t a, input vec_t b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.acc_clr  = clr;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.err_clr   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(0, '0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  vector_t tbl [12];

  initial begin
    int k;
    tbl[0]  = '{2'd0, 1'b0, mk(100,100,100), mk(100,100,100), mk(73,72,71)};
    tbl[1]  = '{2'd1, 1'b0, mk(5,5,5),       mk(10,10,10),    mk(122,123,124)};
    tbl[2]  = '{2'd2, 1'b0, mk(126,127,128), mk(126,127,128), mk(1,1,1)};
    tbl[3]  = '{2'd3, 1'b1, mk(10,10,10),    mk(20,20,20),    mk(73,72,71)};
    tbl[4]  = '{2'd3, 1'b0, mk(10,10,10),    mk(20,20,20),    mk(19,16,13)};
    tbl[5]  = '{2'd0, 1'b1, mk(1,2,3),       mk(4,5,6),       mk(5,7,9)};
    tbl[6]  = '{2'd3, 1'b0, mk(1,1,1),       mk(1,1,1),       mk(1,1,1)};
    tbl[7]  = '{2'd0, 1'b0, mk(0,0,0),       mk(0,200,0),     mk(0,72,0)};
    tbl[8]  = '{2'd1, 1'b0, mk(0,0,0),       mk(0,0,0),       mk(0,0,0)};
    tbl[9]  = '{2'd0, 1'b0, mk(126,127,128), mk(126,127,128), mk(125,126,127)};
    tbl[10] = '{2'd2, 1'b0, mk(255,255,255), mk(255,255,255), mk(1,1,9)};
    tbl[11] = '{2'd1, 1'b0, mk(0,0,0),       mk(255,255,255), mk(126,1,3)};

    for (int i = 0; i < CH; i++) macc[i] = 0;
    m_err         = 1'b0;
    last_acc      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.acc_clr   = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_range_err", bus.range_err, 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency on an empty pipe
    drive(2'd0, 1'b0, mk(100,100,100), mk(100,100,100));
    step(1, mk(73,72,71));
    bus.in_valid = 1'b0;
    chk("lat_cycle1_valid", bus.out_valid, 0);
    step(0, '0);
    chk("lat_cycle2_valid", bus.out_valid, 1);
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].clr, tbl[i].a, tbl[i].b);
      step(1, tbl[i].exp);
      chk("tbl_accept", last_acc, 1);
    end
    drain();

    // Backpressure: four adds with the consumer stalled
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(2'd0, 1'b0, mk(k*10+1, k*10+2, k*10+3), mk(k, k, k));
      step(0, '0);
      if (last_acc) k++;
      if (c >= 2) chk("bp_hold_result", bus.result, exp_q[0]);
    end
    chk("bp_accepts", k, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      drive(2'd0, 1'b0, mk(k*10+1, k*10+2, k*10+3), mk(k, k, k));
      step(0, '0);
      if (last_acc) k++;
    end
    chk("bp_total", k, 4);
    drain();

    // Sticky range error
    bus.err_clr = 1'b1;
    step(0, '0);
    bus.err_clr = 1'b0;
    chk("err_cleared", bus.range_err, 0);
    drive(2'd0, 1'b0, mk(0,0,0), mk(0,200,0));
    step(1, mk(0,72,0));
    bus.in_valid = 1'b0;
    chk("err_set", bus.range_err, 1);
    drive(2'd0, 1'b0, mk(0,0,0), mk(0,200,0));
    bus.err_clr = 1'b1;
    step(1, mk(0,72,0));
    bus.err_clr  = 1'b0;
    bus.in_valid = 1'b0;
    chk("err_set_wins", bus.range_err, 1);
    drain();
    bus.err_clr = 1'b1;
    step(0, '0);
    bus.err_clr = 1'b0;

    // Reset with two transactions in flight and a nonzero accumulator
    drive(2'd3, 1'b1, mk(3,3,3), mk(3,3,3));
    step(1, mk(9,9,9));
    drive(2'd0, 1'b0, mk(1,1,1), mk(2,2,2));
    step(0, '0);
    drive(2'd0, 1'b0, mk(4,4,4), mk(5,5,5));
    step(0, '0);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_result", bus.result, 0);
    exp_q.delete();
    for (int i = 0; i < CH; i++) macc[i] = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd3, 1'b0, mk(1,1,1), mk(1,1,1));
    step(1, mk(1,1,1));
    drain();

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.op        = 2'($urandom_range(0, 3));
      bus.acc_clr   = ($urandom_range(0, 7) == 0);
      bus.a         = vec_t'($urandom);
      bus.b         = vec_t'($urandom);
      bus.err_clr   = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(0, '0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
